// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard control: tracks destination tags through EX/MEM/WB,
// drives the EX operand mux selects and requests stalls on unresolvable hazards.
`ifndef FORW_SEL_FROM_ID
`define FORW_SEL_FROM_ID  2'b00
`define FORW_SEL_FROM_MEM 2'b01
`define FORW_SEL_FROM_WB  2'b10
`endif

module forward_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  forward_en,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  output logic [1:0]            sel_src1,
  output logic [1:0]            sel_src2,
  output logic                  hazard,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  two_src;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_read;
  } stage_t;

  stage_t ex_q, mem_q, wb_q, id_rec;
  logic   fwd_ok, mem_writes, wb_writes;
  logic   ex_match, mem_match;
  logic   unused_fields;

  assign id_rec = '{valid: id_valid, src1: id_src1, src2: id_src2, two_src: id_two_src,
                    dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};

  assign fwd_ok     = forward_en & ex_q.valid;
  assign mem_writes = mem_q.valid & mem_q.wb_en;
  assign wb_writes  = wb_q.valid & wb_q.wb_en;

  // MEM is checked first so the youngest producer wins when both stages match.
  always_comb begin
    sel_src1 = `FORW_SEL_FROM_ID;
    sel_src2 = `FORW_SEL_FROM_ID;
    if (fwd_ok && mem_writes && mem_q.dest == ex_q.src1)
      sel_src1 = `FORW_SEL_FROM_MEM;
    else if (fwd_ok && wb_writes && wb_q.dest == ex_q.src1)
      sel_src1 = `FORW_SEL_FROM_WB;
    if (fwd_ok && ex_q.two_src && mem_writes && mem_q.dest == ex_q.src2)
      sel_src2 = `FORW_SEL_FROM_MEM;
    else if (fwd_ok && ex_q.two_src && wb_writes && wb_q.dest == ex_q.src2)
      sel_src2 = `FORW_SEL_FROM_WB;
  end

  assign ex_match  = ex_q.valid & ex_q.wb_en &
                     ((ex_q.dest == id_src1) | (id_two_src & (ex_q.dest == id_src2)));
  assign mem_match = mem_q.valid & mem_q.wb_en &
                     ((mem_q.dest == id_src1) | (id_two_src & (mem_q.dest == id_src2)));

  // WB writes the register file on the opposite edge, so it never stalls.
  assign hazard = id_valid & (forward_en ? (ex_match & ex_q.mem_read)
                                         : (ex_match | mem_match));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (flush || hazard) ? '0 : id_rec;
      if (hazard && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Later-stage records keep every field; only dest/wb_en/valid are consumed there.
  assign unused_fields = ^{mem_q.src1, mem_q.src2, mem_q.two_src, mem_q.mem_read,
                           wb_q.src1, wb_q.src2, wb_q.two_src, wb_q.mem_read};

endmodule
